// File: rtl/knn_ctrl.sv
// knn_ctrl: drives the external squared-distance core across a dataset and
// keeps a stable, sorted list of the K nearest points for host read-back.
module knn_ctrl #(
  parameter int DATA_W  = 32,
  parameter int K       = 4,
  parameter int N_W     = 8,
  parameter int LABEL_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [N_W-1:0]       n_pts,
  input  logic [DATA_W-1:0]    tx,
  input  logic [DATA_W-1:0]    ty,
  output logic                 mem_en,
  output logic [N_W-1:0]       mem_addr,
  input  logic [DATA_W-1:0]    mem_x,
  input  logic [DATA_W-1:0]    mem_y,
  input  logic [LABEL_W-1:0]   mem_label,
  output logic                 core_en,
  output logic [DATA_W-1:0]    core_x1,
  output logic [DATA_W-1:0]    core_x2,
  output logic [DATA_W-1:0]    core_y1,
  output logic [DATA_W-1:0]    core_y2,
  input  logic [2*DATA_W-1:0]  core_z,
  output logic                 busy,
  output logic                 done,
  input  logic [$clog2(K)-1:0] rd_idx,
  output logic                 rd_valid,
  output logic [2*DATA_W-1:0]  rd_dist,
  output logic [LABEL_W-1:0]   rd_label,
  output logic [N_W-1:0]       rd_pidx
);

  localparam int P_W = $clog2(K + 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_FETCH  = 3'd1;
  localparam logic [2:0] S_CALC   = 3'd2;
  localparam logic [2:0] S_INSERT = 3'd3;
  localparam logic [2:0] S_DONE   = 3'd4;

  logic [2:0]          state;
  logic [N_W-1:0]      n_reg, i_reg, addr_reg, pidx_reg;
  logic [DATA_W-1:0]   tx_reg, ty_reg;
  logic [2*DATA_W-1:0] d_reg;
  logic [LABEL_W-1:0]  lab_reg;
  logic [N_W:0]        i_inc;
  logic                accept;

  logic [2*DATA_W-1:0] slot_dist  [K];
  logic [LABEL_W-1:0]  slot_label [K];
  logic [N_W-1:0]      slot_pidx  [K];
  logic [K-1:0]        slot_valid;

  logic [2*DATA_W-1:0] prev_dist  [K];
  logic [LABEL_W-1:0]  prev_label [K];
  logic [N_W-1:0]      prev_pidx  [K];
  logic [K-1:0]        prev_valid;

  logic [2*DATA_W-1:0] dist_next  [K];
  logic [LABEL_W-1:0]  label_next [K];
  logic [N_W-1:0]      pidx_next  [K];
  logic [K-1:0]        valid_next;

  logic [P_W-1:0]      pos;

  assign accept = (state == S_IDLE) && start;
  assign i_inc  = {1'b0, i_reg} + 1'b1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      n_reg    <= '0;
      i_reg    <= '0;
      addr_reg <= '0;
      pidx_reg <= '0;
      tx_reg   <= '0;
      ty_reg   <= '0;
      d_reg    <= '0;
      lab_reg  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            n_reg  <= n_pts;
            tx_reg <= tx;
            ty_reg <= ty;
            i_reg  <= '0;
            state  <= (n_pts == '0) ? S_DONE : S_FETCH;
          end
        end
        S_FETCH: begin
          addr_reg <= i_reg;
          state    <= S_CALC;
        end
        S_CALC: begin
          d_reg    <= core_z;
          lab_reg  <= mem_label;
          pidx_reg <= i_reg;
          state    <= S_INSERT;
        end
        S_INSERT: begin
          i_reg <= i_inc[N_W-1:0];
          state <= (i_inc < {1'b0, n_reg}) ? S_FETCH : S_DONE;
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // Valid slots are always a sorted prefix, so counting dist <= d gives the
  // stable insertion point directly.
  always_comb begin
    pos = '0;
    for (int k = 0; k < K; k++) begin
      if (slot_valid[k] && (slot_dist[k] <= d_reg)) pos = pos + 1'b1;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < K; gi++) begin : g_slot
      if (gi == 0) begin : g_head
        assign prev_dist[gi]  = '0;
        assign prev_label[gi] = '0;
        assign prev_pidx[gi]  = '0;
        assign prev_valid[gi] = 1'b0;
      end else begin : g_tail
        assign prev_dist[gi]  = slot_dist[gi-1];
        assign prev_label[gi] = slot_label[gi-1];
        assign prev_pidx[gi]  = slot_pidx[gi-1];
        assign prev_valid[gi] = slot_valid[gi-1];
      end
      assign dist_next[gi]  = (P_W'(gi) == pos) ? d_reg    :
                              (P_W'(gi) >  pos) ? prev_dist[gi]  : slot_dist[gi];
      assign label_next[gi] = (P_W'(gi) == pos) ? lab_reg  :
                              (P_W'(gi) >  pos) ? prev_label[gi] : slot_label[gi];
      assign pidx_next[gi]  = (P_W'(gi) == pos) ? pidx_reg :
                              (P_W'(gi) >  pos) ? prev_pidx[gi]  : slot_pidx[gi];
      assign valid_next[gi] = (P_W'(gi) == pos) ? 1'b1     :
                              (P_W'(gi) >  pos) ? prev_valid[gi] : slot_valid[gi];
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < K; k++) begin
        slot_dist[k]  <= '0;
        slot_label[k] <= '0;
        slot_pidx[k]  <= '0;
      end
      slot_valid <= '0;
    end else if (accept) begin
      for (int k = 0; k < K; k++) begin
        slot_dist[k]  <= '0;
        slot_label[k] <= '0;
        slot_pidx[k]  <= '0;
      end
      slot_valid <= '0;
    end else if ((state == S_INSERT) && (pos < P_W'(K))) begin
      for (int k = 0; k < K; k++) begin
        slot_dist[k]  <= dist_next[k];
        slot_label[k] <= label_next[k];
        slot_pidx[k]  <= pidx_next[k];
      end
      slot_valid <= valid_next;
    end
  end

  assign mem_en   = (state == S_FETCH);
  assign mem_addr = mem_en ? i_reg : addr_reg;
  assign core_en  = (state == S_CALC);
  assign core_x1  = core_en ? mem_x  : '0;
  assign core_x2  = core_en ? tx_reg : '0;
  assign core_y1  = core_en ? mem_y  : '0;
  assign core_y2  = core_en ? ty_reg : '0;
  assign busy     = (state == S_FETCH) || (state == S_CALC) || (state == S_INSERT);
  assign done     = (state == S_DONE);

  assign rd_valid = slot_valid[rd_idx];
  assign rd_dist  = slot_dist[rd_idx];
  assign rd_label = slot_label[rd_idx];
  assign rd_pidx  = slot_pidx[rd_idx];

endmodule
